// File: rtl/popcount_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined popcount block:
// leaf geometry, count widths, and the mapping of tree levels onto register stages.
package popcount_pkg;

    localparam int LEAF_W     = 8;
    localparam int LEAF_CNT_W = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int tree_levels(input int width);
        return $clog2(width / LEAF_W);
    endfunction

    // Stage that owns tree level lvl when n levels are spread over d stages;
    // the first n%d stages each take one extra level.
    function automatic int level_stage(input int lvl, input int n, input int d);
        int q;
        int r;
        if (d < 1 || n < d) return 0;
        q = n / d;
        r = n % d;
        if (lvl < r * (q + 1)) return lvl / (q + 1);
        return r + (lvl - r * (q + 1)) / q;
    endfunction

    function automatic int level_bits(input int lvl, input int channels, input int leaves);
        return channels * (leaves >> lvl) * (LEAF_CNT_W + lvl);
    endfunction

    function automatic int level_off(input int lvl, input int channels, input int leaves);
        int off;
        off = 0;
        for (int j = 0; j < lvl; j++) off += level_bits(j, channels, leaves);
        return off;
    endfunction

endpackage

// File: rtl/popcount_pipe_8bit.sv
// Leaf counter: number of set bits in one byte, purely combinational.
module popcount_8bit
    import popcount_pkg::*;
(
    input  logic [LEAF_W-1:0]     byte_i,
    output logic [LEAF_CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int b = 0; b < LEAF_W; b++) begin
            count_o = count_o + LEAF_CNT_W'(byte_i[b]);
        end
    end

endmodule

// File: rtl/popcount_pipe.sv
// Multi-channel popcount with count0-count1 score; PIPE_DEPTH cycles latency, 1 beat/cycle.
// Valid/ready both sides; a stalled output holds, upstream stages fill, then in_ready drops.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int  WIDTH      = 64,
    parameter int  CHANNELS   = 2,
    parameter int  TAG_W      = 8,
    parameter int  PIPE_DEPTH = 2,
    localparam int CNT_W      = cnt_w(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*CNT_W-1:0]  out_count,
    output logic signed [CNT_W:0]      out_diff,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int LEVELS   = tree_levels(WIDTH);
    localparam int NB       = WIDTH / LEAF_W;
    localparam int NP       = 1 << LEVELS;
    localparam int D        = PIPE_DEPTH;
    localparam int TOP_W    = LEAF_CNT_W + LEVELS;
    localparam int TOP_OFF  = level_off(LEVELS, CHANNELS, NP);
    localparam int TOT_BITS = level_off(LEVELS + 1, CHANNELS, NP);

    if (WIDTH < LEAF_W || (WIDTH % LEAF_W) != 0) begin : g_bad_width
        $error("popcount_pipe: WIDTH must be a multiple of 8 and at least 8");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > LEVELS + 1) begin : g_bad_depth
        $error("popcount_pipe: PIPE_DEPTH must lie in 1..1+clog2(WIDTH/8)");
    end
    if (CHANNELS < 1) begin : g_bad_ch
        $error("popcount_pipe: CHANNELS must be at least 1");
    end

    // ld[s]: stage s may load this cycle; the chain ends at out_ready.
    logic [D:0]                 ld;
    logic [D-1:0]               v_q;
    logic [D-1:0]               v_d;
    logic [D-1:0]               en;
    logic [D-1:0][TAG_W-1:0]    tag_in;

    assign ld[D]    = out_ready;
    assign in_ready = ld[0] && !rst;

    for (genvar s = 0; s < D; s++) begin : g_ctl
        assign ld[s] = !v_q[s] || ld[s+1];
        if (s == 0) begin : g_first
            assign en[s] = in_valid && in_ready;
        end else begin : g_next
            assign en[s] = ld[s] && v_q[s-1];
        end
    end

    always_comb begin
        v_d = v_q;
        if (ld[0]) v_d[0] = in_valid;
        for (int s = 1; s < D; s++) begin
            if (ld[s]) v_d[s] = v_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    assign tag_in[0] = in_tag;
    for (genvar s = 0; s < D - 1; s++) begin : g_tag
        logic [TAG_W-1:0] tag_q;
        always_ff @(posedge clk) begin
            if (en[s]) tag_q <= tag_in[s];
        end
        assign tag_in[s+1] = tag_q;
    end

    // Every tree level lives in one flat vector; a level is registered when the
    // next level belongs to a later stage.
    logic [TOT_BITS-1:0] fwd;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int  SW    = LEAF_CNT_W + l;
        localparam int  NS    = NP >> l;
        localparam int  OFF   = level_off(l, CHANNELS, NP);
        localparam int  BITS  = level_bits(l, CHANNELS, NP);
        localparam int  ST    = level_stage(l, LEVELS + 1, D);
        localparam bit  BREAK = (l < LEVELS) && (level_stage(l + 1, LEVELS + 1, D) != ST);

        logic [BITS-1:0] sum_c;

        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            for (genvar i = 0; i < NS; i++) begin : g_el
                if (l == 0) begin : g_leaf
                    if (i < NB) begin : g_byte
                        popcount_8bit u_leaf (
                            .byte_i  (in_data[c*WIDTH + i*LEAF_W +: LEAF_W]),
                            .count_o (sum_c[(c*NS + i)*SW +: SW])
                        );
                    end else begin : g_pad
                        assign sum_c[(c*NS + i)*SW +: SW] = '0;
                    end
                end else begin : g_add
                    localparam int PW = SW - 1;
                    localparam int PO = level_off(l - 1, CHANNELS, NP);
                    assign sum_c[(c*NS + i)*SW +: SW] =
                        SW'(fwd[PO + (c*2*NS + 2*i)*PW +: PW]) +
                        SW'(fwd[PO + (c*2*NS + 2*i + 1)*PW +: PW]);
                end
            end
        end

        if (BREAK) begin : g_reg
            logic [BITS-1:0] sum_q;
            always_ff @(posedge clk) begin
                if (en[ST]) sum_q <= sum_c;
            end
            assign fwd[OFF +: BITS] = sum_q;
        end else begin : g_comb
            assign fwd[OFF +: BITS] = sum_c;
        end
    end

    logic [CHANNELS*CNT_W-1:0] count_d;
    logic signed [CNT_W:0]     diff_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
        assign count_d[c*CNT_W +: CNT_W] = fwd[TOP_OFF + c*TOP_W +: CNT_W];
    end

    if (CHANNELS > 1) begin : g_diff2
        assign diff_d = $signed({1'b0, count_d[0 +: CNT_W]}) - $signed({1'b0, count_d[CNT_W +: CNT_W]});
    end else begin : g_diff1
        assign diff_d = $signed({1'b0, count_d[0 +: CNT_W]});
    end

    logic [CHANNELS*CNT_W-1:0] count_q;
    logic signed [CNT_W:0]     diff_q;
    logic [TAG_W-1:0]          otag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            diff_q  <= '0;
            otag_q  <= '0;
        end else if (en[D-1]) begin
            count_q <= count_d;
            diff_q  <= diff_d;
            otag_q  <= tag_in[D-1];
        end
    end

    assign out_valid = v_q[D-1];
    assign out_count = count_q;
    assign out_diff  = diff_q;
    assign out_tag   = otag_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Scoreboard bench for popcount_pipe: random and directed beats against a $countones model,
// plus two extra instances exercising the smallest and a wide/deep configuration.
module tb_popcount_pipe;

    localparam int WIDTH = 64;
    localparam int CH    = 2;
    localparam int TAG_W = 8;
    localparam int PD    = 2;
    localparam int CNT_W = 7;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH*WIDTH-1:0]      in_data;
    logic [TAG_W-1:0]         in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH*CNT_W-1:0]      out_count;
    logic signed [CNT_W:0]    out_diff;
    logic [TAG_W-1:0]         out_tag;

    logic                     s1_in_valid, s1_in_ready, s1_out_valid;
    logic [7:0]               s1_in_data;
    logic [7:0]               s1_in_tag, s1_out_tag;
    logic [3:0]               s1_out_count;
    logic signed [4:0]        s1_out_diff;

    logic                     s2_in_valid, s2_in_ready, s2_out_valid;
    logic [511:0]             s2_in_data;
    logic [7:0]               s2_in_tag, s2_out_tag;
    logic [31:0]              s2_out_count;
    logic signed [8:0]        s2_out_diff;
    logic                     s_out_ready;

    always #5 clk = ~clk;

    popcount_pipe #(.WIDTH(WIDTH), .CHANNELS(CH), .TAG_W(TAG_W), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_diff(out_diff), .out_tag(out_tag)
    );

    popcount_pipe #(.WIDTH(8), .CHANNELS(1), .TAG_W(8), .PIPE_DEPTH(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_data(s1_in_data), .in_tag(s1_in_tag), .out_valid(s1_out_valid), .out_ready(s_out_ready),
        .out_count(s1_out_count), .out_diff(s1_out_diff), .out_tag(s1_out_tag)
    );

    popcount_pipe #(.WIDTH(128), .CHANNELS(4), .TAG_W(8), .PIPE_DEPTH(5)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .in_data(s2_in_data), .in_tag(s2_in_tag), .out_valid(s2_out_valid), .out_ready(s_out_ready),
        .out_count(s2_out_count), .out_diff(s2_out_diff), .out_tag(s2_out_tag)
    );

    typedef struct {
        int         c0;
        int         c1;
        int         diff;
        logic [7:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_out_cyc = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [CH*WIDTH-1:0] d, input logic [7:0] t);
        exp_t e;
        e.c0   = $countones(d[WIDTH-1:0]);
        e.c1   = $countones(d[2*WIDTH-1:WIDTH]);
        e.diff = e.c0 - e.c1;
        e.tag  = t;
        return e;
    endfunction

    function automatic logic [CH*WIDTH-1:0] rand_data();
        logic [CH*WIDTH-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
            0: d[63:0]   = '1;
            1: d[127:64] = '1;
            2: d[63:0]   = '0;
            3: d         = d & {$urandom, $urandom, $urandom, $urandom};
            default: ;
        endcase
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented result is compared with the scoreboard head,
    // so held outputs are checked on each stalled cycle as well.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", longint'(out_valid), 0);
                end else begin
                    check("out_count0", longint'(out_count[CNT_W-1:0]), sb[0].c0);
                    check("out_count1", longint'(out_count[2*CNT_W-1:CNT_W]), sb[0].c1);
                    check("out_diff", longint'($signed(out_diff)), sb[0].diff);
                    check("out_tag", longint'(out_tag), longint'(sb[0].tag));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                        last_out_cyc = cyc;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_tag));
        end
    end

    task automatic send(input logic [CH*WIDTH-1:0] d, input logic [7:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            stall_cnt++;
            @(negedge clk);
        end
        if (n >= 50) check("send_accept", longint'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic wait_valid(input int which, output int lat);
        logic v;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            case (which)
                0:       v = out_valid;
                1:       v = s1_out_valid;
                default: v = s2_out_valid;
            endcase
        end while (!v && lat < 50);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int lat;
        int t0;
        int n0;
        logic [CH*WIDTH-1:0] d;
        logic [511:0]        w;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        s1_in_valid = 1'b0; s1_in_data = '0; s1_in_tag = '0;
        s2_in_valid = 1'b0; s2_in_data = '0; s2_in_tag = '0;
        s_out_ready = 1'b1;

        // Reset release; beats offered during reset must never surface.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = rand_data();
            in_tag  = 8'(8'hE0 + i);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_count", longint'(out_count), 0);
        check("rst_out_diff", longint'($signed(out_diff)), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        repeat (4) @(negedge clk);
        check("rst_no_output", longint'(out_valid), 0);
        @(posedge clk);
        #1;

        // Extremes with latency measurement.
        send({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 8'hA5);
        in_valid = 1'b0;
        wait_valid(0, lat);
        check("lat_extreme", lat, PD);
        check("ext_count0", longint'(out_count[CNT_W-1:0]), 64);
        check("ext_count1", longint'(out_count[2*CNT_W-1:CNT_W]), 0);
        check("ext_diff", longint'($signed(out_diff)), 64);
        check("ext_tag", longint'(out_tag), 8'hA5);
        @(posedge clk);
        #1;
        send({64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 8'h5A);
        in_valid = 1'b0;
        wait_valid(0, lat);
        check("lat_swap", lat, PD);
        check("swap_diff", longint'($signed(out_diff)), -64);
        drain();

        // 100 back-to-back beats: no input stalls, no output bubbles.
        stall_cnt = 0;
        n0 = n_out;
        t0 = cyc;
        for (int i = 0; i < 100; i++) send(rand_data(), 8'(i));
        in_valid = 1'b0;
        drain();
        check("stream_stalls", stall_cnt, 0);
        check("stream_outputs", n_out - n0, 100);
        check("stream_no_bubbles", last_out_cyc, t0 + PD + 99);

        // Five-cycle output stall in the middle of a stream.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 30; i++) send(rand_data(), 8'(8'h40 + i));
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_in_ready", longint'(in_ready), 0);
                check("bp_held_beats", sb.size(), PD);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_outputs", n_out - n0, 30);

        // Random valid gaps and random output readiness.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rand_data(), 8'($urandom));
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_outputs", n_out - n0, 60);

        // Reset with two beats held inside the pipe.
        out_ready = 1'b0;
        send(rand_data(), 8'h11);
        send(rand_data(), 8'h22);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_output", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send({64'h3, 64'h1}, 8'h77);
        in_valid = 1'b0;
        wait_valid(0, lat);
        check("post_rst_latency", lat, PD);
        check("post_rst_count0", longint'(out_count[CNT_W-1:0]), 1);
        check("post_rst_count1", longint'(out_count[2*CNT_W-1:CNT_W]), 2);
        check("post_rst_diff", longint'($signed(out_diff)), -1);
        drain();

        // Smallest configuration: one byte, one channel, single stage.
        s1_in_data  = 8'hFF;
        s1_in_tag   = 8'h3C;
        s1_in_valid = 1'b1;
        @(negedge clk);
        check("s1_in_ready", longint'(s1_in_ready), 1);
        @(posedge clk);
        #1;
        s1_in_valid = 1'b0;
        wait_valid(1, lat);
        check("s1_latency", lat, 1);
        check("s1_count", longint'(s1_out_count), 8);
        check("s1_diff", longint'($signed(s1_out_diff)), 8);
        check("s1_tag", longint'(s1_out_tag), 8'h3C);
        @(posedge clk);
        #1;

        // Wide configuration: 128-bit boards, four channels, five stages.
        s2_in_data  = '1;
        s2_in_tag   = 8'hC3;
        s2_in_valid = 1'b1;
        @(negedge clk);
        check("s2_in_ready", longint'(s2_in_ready), 1);
        @(posedge clk);
        #1;
        s2_in_valid = 1'b0;
        wait_valid(2, lat);
        check("s2_latency", lat, 5);
        check("s2_count0", longint'(s2_out_count[7:0]), 128);
        check("s2_count3", longint'(s2_out_count[31:24]), 128);
        check("s2_diff_equal", longint'($signed(s2_out_diff)), 0);
        check("s2_tag", longint'(s2_out_tag), 8'hC3);
        @(posedge clk);
        #1;
        w = '0;
        w[127:0] = '1;
        s2_in_data  = w;
        s2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s2_in_valid = 1'b0;
        wait_valid(2, lat);
        check("s2_latency2", lat, 5);
        check("s2_count1_zero", longint'(s2_out_count[15:8]), 0);
        check("s2_diff_max", longint'($signed(s2_out_diff)), 128);

        d = '0;
        repeat (3) @(posedge clk);
        #1;
        check("end_sb_empty", sb.size() + int'(d[0]), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
